// File: rtl/gear_speed_meter.sv
// Wheel-speed front end: synchronise and debounce the wheel pulse, count edges per gate window,
// publish an 8-bit speed once per window and derive a hysteretic gear request (gear 1..4).
module gear_speed_meter #(
  parameter int unsigned WINDOW_CYCLES = 2500,
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned UP12          = 10,
  parameter int unsigned UP23          = 20,
  parameter int unsigned UP34          = 30,
  parameter int unsigned HYST          = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       pulse_in,
  output logic [7:0] speed,
  output logic       speed_valid,
  output logic [1:0] gear,
  output logic       shift_up,
  output logic       shift_down
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [7:0] UP12_V = 8'(UP12);
  localparam logic [7:0] UP23_V = 8'(UP23);
  localparam logic [7:0] UP34_V = 8'(UP34);
  localparam logic [7:0] DN21_V = 8'(UP12 - HYST);
  localparam logic [7:0] DN32_V = 8'(UP23 - HYST);
  localparam logic [7:0] DN43_V = 8'(UP34 - HYST);

  typedef enum logic [1:0] {G1 = 2'd0, G2 = 2'd1, G3 = 2'd2, G4 = 2'd3} gear_t;

  logic             sync_1, sync_2;
  logic             filt, filt_d;
  logic [DEB_W-1:0] deb_cnt;
  logic             rise;

  // Input path runs regardless of ena so the filter never sees a stale level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_1 <= pulse_in;
      sync_2 <= sync_1;
      filt_d <= filt;
      if (sync_2 == filt) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        filt    <= ~filt;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign rise = filt & ~filt_d;

  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       edge_cnt;
  logic [7:0]       edge_sum;
  logic             terminal;
  logic             eval_pend;

  assign terminal = ena && (win_cnt == WIN_LAST);
  assign edge_sum = (rise && (edge_cnt != 8'hFF)) ? edge_cnt + 1'b1 : edge_cnt;

  // eval_pend marks a fresh speed; it survives ena-low cycles so the gear step is deferred, not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      eval_pend   <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (ena) begin
        if (terminal) begin
          win_cnt     <= '0;
          edge_cnt    <= '0;
          speed       <= edge_sum;
          speed_valid <= 1'b1;
        end else begin
          win_cnt  <= win_cnt + 1'b1;
          edge_cnt <= edge_sum;
        end
      end
      if (terminal) begin
        eval_pend <= 1'b1;
      end else if (ena) begin
        eval_pend <= 1'b0;
      end
    end
  end

  gear_t state_q, state_d;
  logic  up_d, dn_d;

  always_comb begin
    state_d = state_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    if (eval_pend && ena) begin
      unique case (state_q)
        G1: if (speed >= UP12_V) begin state_d = G2; up_d = 1'b1; end
        G2: if (speed >= UP23_V) begin state_d = G3; up_d = 1'b1; end
            else if (speed < DN21_V) begin state_d = G1; dn_d = 1'b1; end
        G3: if (speed >= UP34_V) begin state_d = G4; up_d = 1'b1; end
            else if (speed < DN32_V) begin state_d = G2; dn_d = 1'b1; end
        G4: if (speed < DN43_V) begin state_d = G3; dn_d = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= G1;
      shift_up   <= 1'b0;
      shift_down <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_up   <= up_d;
      shift_down <= dn_d;
    end
  end

  assign gear = state_q;

endmodule

// File: tb/tb_gear_speed_meter.sv
// Scoreboard bench for gear_speed_meter: instance A (100-cycle window, DEB 4) and
// instance B (1000-cycle window, DEB 1) for the high-speed hysteresis and saturation windows.
module tb_gear_speed_meter;

  localparam int T_END = 10500;

  typedef struct {
    int         cyc;
    logic [7:0] spd;
    logic [1:0] gr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ena_a, ena_b, pa, pb;
  logic [7:0] speed_a, speed_b;
  logic       speed_valid_a, speed_valid_b;
  logic [1:0] gear_a, gear_b;
  logic       shift_up_a, shift_up_b, shift_down_a, shift_down_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic run = 1'b0;

  exp_t qa[$];
  exp_t qb[$];

  logic [7:0] spd_a [10] = '{8'd10, 8'd10, 8'd10, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd10, 8'd0};
  logic [1:0] gr_a  [10] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
  int         nb    [10] = '{32, 32, 32, 28, 26, 16, 18, 300, 0, 0};
  logic [7:0] spd_b [10] = '{8'd32, 8'd32, 8'd32, 8'd28, 8'd26, 8'd16, 8'd18, 8'd255, 8'd0, 8'd0};
  logic [1:0] gr_b  [10] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0};

  always #5 clk = ~clk;

  gear_speed_meter #(.WINDOW_CYCLES(100), .DEB_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .ena(ena_a), .pulse_in(pa),
    .speed(speed_a), .speed_valid(speed_valid_a), .gear(gear_a),
    .shift_up(shift_up_a), .shift_down(shift_down_a)
  );

  gear_speed_meter #(.WINDOW_CYCLES(1000), .DEB_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .ena(ena_b), .pulse_in(pb),
    .speed(speed_b), .speed_valid(speed_valid_b), .gear(gear_b),
    .shift_up(shift_up_b), .shift_down(shift_down_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic pa_level(input int t);
    if (t < 295) return (t % 10) < 5;
    if (t >= 300 && t < 390) return (t % 10) < 3;
    if (t >= 410 && t < 416) return (t % 2) == 0;
    if (t >= 416 && t < 450) return 1'b1;
    if (t >= 593 && t <= 620) return 1'b1;
    if (t >= 694 && t <= 720) return 1'b1;
    if (t >= 800 && t < 945) return (t % 10) < 5;
    return 1'b0;
  endfunction

  function automatic logic pb_level(input int t);
    int k;
    int off;
    k = t / 1000;
    off = t % 1000;
    if (k >= 10) return 1'b0;
    return (off >= 10) && (off < 10 + 2 * nb[k]) && ((off % 2) == 0);
  endfunction

  // Monitor A
  logic       gchk_a = 1'b0;
  logic [1:0] ga_exp = '0, ga_prev = '0;
  always @(negedge clk) begin
    exp_t e;
    if (run && !rst) begin
      if (gchk_a) begin
        check("a_gear", gear_a, ga_exp);
        check("a_shift", {shift_up_a, shift_down_a}, {ga_exp > ga_prev, ga_exp < ga_prev});
        ga_prev = ga_exp;
        gchk_a = 1'b0;
      end else if (shift_up_a || shift_down_a) begin
        check("a_stray_shift", {shift_up_a, shift_down_a}, 0);
      end
      if (!ena_a && (speed_valid_a || shift_up_a || shift_down_a))
        check("a_pulse_ena_low", 1, 0);
      if (speed_valid_a) begin
        if (qa.size() == 0) begin
          check("a_extra_valid", 1, 0);
        end else begin
          e = qa.pop_front();
          check("a_valid_cycle", cyc, e.cyc);
          check("a_speed", speed_a, e.spd);
          ga_exp = e.gr;
          gchk_a = 1'b1;
        end
      end
    end
  end

  // Monitor B
  logic       gchk_b = 1'b0;
  logic [1:0] gb_exp = '0, gb_prev = '0;
  always @(negedge clk) begin
    exp_t e;
    if (run && !rst) begin
      if (gchk_b) begin
        check("b_gear", gear_b, gb_exp);
        check("b_shift", {shift_up_b, shift_down_b}, {gb_exp > gb_prev, gb_exp < gb_prev});
        gb_prev = gb_exp;
        gchk_b = 1'b0;
      end else if (shift_up_b || shift_down_b) begin
        check("b_stray_shift", {shift_up_b, shift_down_b}, 0);
      end
      if (speed_valid_b) begin
        if (qb.size() == 0) begin
          check("b_extra_valid", 1, 0);
        end else begin
          e = qb.pop_front();
          check("b_valid_cycle", cyc, e.cyc);
          check("b_speed", speed_b, e.spd);
          gb_exp = e.gr;
          gchk_b = 1'b1;
        end
      end
    end
  end

  initial begin
    exp_t e;
    int a_start;
    int ka;
    rst = 1'b1; pa = 1'b0; pb = 1'b0; ena_a = 1'b1; ena_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      pa = (i % 10) < 5;
      pb = pa;
      @(posedge clk);
      #1;
    end
    // Mid-window reset with pulses still toggling.
    for (int r = 0; r < 3; r++) begin
      rst = 1'b1;
      pa = ((50 + r) % 10) < 5;
      pb = pa;
      @(negedge clk);
      if (r > 0) begin
        check("a_rst_outputs", {speed_a, speed_valid_a, gear_a, shift_up_a, shift_down_a}, 0);
        check("b_rst_outputs", {speed_b, speed_valid_b, gear_b, shift_up_b, shift_down_b}, 0);
      end
      @(posedge clk);
      #1;
    end

    run = 1'b1;
    a_start = 0;
    ka = 0;
    for (int t = 0; t < T_END; t++) begin
      cyc = t;
      rst = 1'b0;
      if (t == a_start) begin
        a_start += (ka == 8) ? 150 : 100;
        e.cyc = a_start;
        e.spd = (ka < 10) ? spd_a[ka] : 8'd0;
        e.gr  = (ka < 10) ? gr_a[ka] : 2'd0;
        if (a_start + 1 < T_END) qa.push_back(e);
        ka++;
      end
      if ((t % 1000) == 0 && (t / 1000) < 10) begin
        e.cyc = t + 1000;
        e.spd = spd_b[t / 1000];
        e.gr  = gr_b[t / 1000];
        qb.push_back(e);
      end
      pa = pa_level(t);
      pb = pb_level(t);
      ena_a = !(t >= 820 && t < 870);
      @(negedge clk);
      if (t == 0) begin
        check("a_post_rst_outputs", {speed_a, speed_valid_a, gear_a, shift_up_a, shift_down_a}, 0);
        check("b_post_rst_outputs", {speed_b, speed_valid_b, gear_b, shift_up_b, shift_down_b}, 0);
      end
      @(posedge clk);
      #1;
    end
    check("a_missing_valids", qa.size(), 0);
    check("b_missing_valids", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
